regfile_write_queue: RTL and testbench



---
 rtl/regfile_write_queue_pkg.sv | 13 +
 rtl/regfile_write_queue_if.sv | 13 +
 rtl/regfile_write_queue_wq_bypass_match.sv | 28 ++
 rtl/regfile_write_queue.sv | 50 +++++
 tb/tb_regfile_write_queue.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/regfile_write_queue_pkg.sv
// regfile_write_queue_pkg: shared widths, queue depth and the write-entry struct {valid, wreg, data} reused by pipeline-stage registers
package regfile_write_queue_pkg;
  localparam int DATA_W = 20;
  localparam int ADDR_W = 4;
  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  typedef struct packed {
    logic valid;
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] data;
  } wq_entry_t;
endpackage

// File: rtl/regfile_write_queue_if.sv
// regfile_write_queue_if: push handshake (in_valid/in_reg/in_data/in_ready) plus register file write port (WriteReg/WriteData/WriteEnable); slave = queue, master = pipeline/register file side
interface regfile_write_queue_if;
  import regfile_write_queue_pkg::*;
  logic in_valid;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;
  logic in_ready;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic WriteEnable;
  modport master (output in_valid, in_reg, in_data, input in_ready, WriteReg, WriteData, WriteEnable);
  modport slave (input in_valid, in_reg, in_data, output in_ready, WriteReg, WriteData, WriteEnable);
endinterface

// File: rtl/regfile_write_queue_wq_bypass_match.sv
// wq_bypass_match: newest-first search of queued entries (tail-1 back to head) for addr; outputs hit and the newest matching data (0 on miss)
module wq_bypass_match
  import regfile_write_queue_pkg::*;
(
  input  wq_entry_t         entries [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [PTR_W-1:0]  tail,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);
  logic [PTR_W-1:0] idx;
  logic stop;
  always_comb begin
    hit = 1'b0;
    data = '0;
    stop = 1'b0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail - PTR_W'(i + 1);
      if (!hit && !stop && entries[idx].valid && entries[idx].wreg == addr) begin
        hit = 1'b1;
        data = entries[idx].data;
      end
      stop = stop || (idx == head);
    end
  end
endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: in-order writeback FIFO draining one entry per cycle to the register file (bus), with two-port bypass lookup (rd_addr*/rd_hit*/rd_data*), hold, pending and empty
module regfile_write_queue
  import regfile_write_queue_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic               hold,
  regfile_write_queue_if.slave bus,
  input  logic [ADDR_W-1:0]  rd_addr1,
  input  logic [ADDR_W-1:0]  rd_addr2,
  output logic               rd_hit1,
  output logic               rd_hit2,
  output logic [DATA_W-1:0]  rd_data1,
  output logic [DATA_W-1:0]  rd_data2,
  output logic [CNT_W-1:0]   pending,
  output logic               empty
);
  wq_entry_t q [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic push, pop;
  assign empty = count == '0;
  assign pending = count;
  assign bus.in_ready = count != CNT_W'(DEPTH);
  assign bus.WriteEnable = !empty && !hold;
  assign bus.WriteReg = empty ? '0 : q[head].wreg;
  assign bus.WriteData = empty ? '0 : q[head].data;
  assign push = bus.in_valid && bus.in_ready;
  assign pop = bus.WriteEnable;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
    end else begin
      if (push) begin
        q[tail] <= '{valid: 1'b1, wreg: bus.in_reg, data: bus.in_data};
        tail <= tail + 1'b1;
      end
      if (pop) begin
        q[head].valid <= 1'b0;
        head <= head + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  wq_bypass_match u_match1 (.entries(q), .head(head), .tail(tail), .addr(rd_addr1), .hit(rd_hit1), .data(rd_data1));
  wq_bypass_match u_match2 (.entries(q), .head(head), .tail(tail), .addr(rd_addr2), .hit(rd_hit2), .data(rd_data2));
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed scenario tasks against a falling-edge register file model
module tb_regfile_write_queue;
  import regfile_write_queue_pkg::*;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic hold = 1'b0;
  logic [ADDR_W-1:0] rd_addr1 = '0, rd_addr2 = '0;
  logic rd_hit1, rd_hit2;
  logic [DATA_W-1:0] rd_data1, rd_data2;
  logic [CNT_W-1:0] pending;
  logic empty;
  logic [DATA_W-1:0] rf [16] = '{default: '0};
  logic [DATA_W-1:0] snap [16];
  int total = 0;
  int bad = 0;
  regfile_write_queue_if bus();
  regfile_write_queue dut (
    .clock(clock), .resetn(resetn), .hold(hold), .bus(bus),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_hit1(rd_hit1), .rd_hit2(rd_hit2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .pending(pending), .empty(empty)
  );
  always #5 clock = ~clock;
  always @(negedge clock) if (bus.WriteEnable) rf[bus.WriteReg] <= bus.WriteData;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    bus.in_valid = v;
    bus.in_reg = r;
    bus.in_data = d;
  endtask
  task automatic test_reset();
    drive(1'b0, '0, '0);
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0h exp=1", bus.in_ready); end
    total++; if (bus.WriteEnable !== 1'b0) begin bad++; $display("FAIL reset_we got=%0h exp=0", bus.WriteEnable); end
    total++; if (bus.WriteReg !== 4'h0 || bus.WriteData !== 20'h0) begin bad++; $display("FAIL reset_wport got=%0h/%0h exp=0/0", bus.WriteReg, bus.WriteData); end
    total++; if (pending !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL reset_pending got=%0d/%0h exp=0/1", pending, empty); end
    total++; if (rd_hit1 !== 1'b0 || rd_hit2 !== 1'b0) begin bad++; $display("FAIL reset_hit got=%0h/%0h exp=0/0", rd_hit1, rd_hit2); end
  endtask
  task automatic test_single();
    drive(1'b1, 4'd1, 20'h00001);
    step();
    drive(1'b0, '0, '0);
    total++; if (bus.WriteEnable !== 1'b1 || bus.WriteReg !== 4'd1 || bus.WriteData !== 20'h00001) begin bad++; $display("FAIL single_present got=%0h/%0h/%0h exp=1/1/1", bus.WriteEnable, bus.WriteReg, bus.WriteData); end
    total++; if (pending !== 3'd1 || empty !== 1'b0) begin bad++; $display("FAIL single_pending got=%0d/%0h exp=1/0", pending, empty); end
    step();
    total++; if (empty !== 1'b1 || bus.WriteEnable !== 1'b0) begin bad++; $display("FAIL single_empty got=%0h/%0h exp=1/0", empty, bus.WriteEnable); end
    total++; if (rf[1] !== 20'h00001) begin bad++; $display("FAIL single_rf got=%0h exp=1", rf[1]); end
  endtask
  task automatic test_full();
    hold = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      drive(1'b1, 4'(i), 20'(i));
      step();
    end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0h exp=0", bus.in_ready); end
    total++; if (pending !== 3'd4 || bus.WriteEnable !== 1'b0) begin bad++; $display("FAIL full_hold got=%0d/%0h exp=4/0", pending, bus.WriteEnable); end
    drive(1'b1, 4'd6, 20'h6);
    step();
    drive(1'b0, '0, '0);
    total++; if (pending !== 3'd4) begin bad++; $display("FAIL full_ignore got=%0d exp=4", pending); end
    hold = 1'b0;
    #1;
    for (int i = 2; i <= 5; i++) begin
      total++; if (bus.WriteEnable !== 1'b1 || bus.WriteReg !== 4'(i) || bus.WriteData !== 20'(i)) begin bad++; $display("FAIL full_drain%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, bus.WriteEnable, bus.WriteReg, bus.WriteData, i, i); end
      step();
    end
    total++; if (empty !== 1'b1 || rf[6] !== 20'h0 || rf[5] !== 20'h5) begin bad++; $display("FAIL full_after got=%0h/%0h/%0h exp=1/0/5", empty, rf[6], rf[5]); end
  endtask
  task automatic test_bypass();
    hold = 1'b1;
    drive(1'b1, 4'd7, 20'hA);
    step();
    drive(1'b1, 4'd7, 20'hB);
    step();
    drive(1'b0, '0, '0);
    rd_addr1 = 4'd7;
    rd_addr2 = 4'd3;
    #1;
    total++; if (rd_hit1 !== 1'b1 || rd_data1 !== 20'hB) begin bad++; $display("FAIL bypass_newest got=%0h/%0h exp=1/b", rd_hit1, rd_data1); end
    total++; if (rd_hit2 !== 1'b0 || rd_data2 !== 20'h0) begin bad++; $display("FAIL bypass_miss got=%0h/%0h exp=0/0", rd_hit2, rd_data2); end
    rd_addr2 = 4'd7;
    hold = 1'b0;
    #1;
    total++; if (rd_hit2 !== 1'b1 || rd_data2 !== 20'hB || bus.WriteData !== 20'hA) begin bad++; $display("FAIL bypass_port2 got=%0h/%0h/%0h exp=1/b/a", rd_hit2, rd_data2, bus.WriteData); end
    step();
    total++; if (rd_hit1 !== 1'b1 || rd_data1 !== 20'hB) begin bad++; $display("FAIL bypass_head got=%0h/%0h exp=1/b", rd_hit1, rd_data1); end
    step();
    total++; if (rd_hit1 !== 1'b0 || rd_data1 !== 20'h0) begin bad++; $display("FAIL bypass_drop got=%0h/%0h exp=0/0", rd_hit1, rd_data1); end
    total++; if (rf[7] !== 20'hB) begin bad++; $display("FAIL bypass_rf got=%0h exp=b", rf[7]); end
  endtask
  task automatic test_back_to_back();
    hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 4'(k + 8), 20'h100 + 20'(k));
      step();
    end
    hold = 1'b0;
    for (int k = 2; k < 10; k++) begin
      drive(1'b1, 4'(k + 8), 20'h100 + 20'(k));
      #1;
      total++; if (pending !== 3'd2 || bus.WriteData !== 20'h100 + 20'(k - 2) || bus.WriteReg !== 4'(k + 6)) begin bad++; $display("FAIL stream%0d got=%0d/%0h/%0h exp=2/%0h/%0h", k, pending, bus.WriteData, bus.WriteReg, 20'h100 + 20'(k - 2), 4'(k + 6)); end
      step();
    end
    drive(1'b0, '0, '0);
    for (int k = 8; k < 10; k++) begin
      total++; if (bus.WriteEnable !== 1'b1 || bus.WriteData !== 20'h100 + 20'(k)) begin bad++; $display("FAIL stream_tail%0d got=%0h/%0h exp=1/%0h", k, bus.WriteEnable, bus.WriteData, 20'h100 + 20'(k)); end
      step();
    end
    total++; if (empty !== 1'b1 || rf[1] !== 20'h109 || rf[15] !== 20'h107) begin bad++; $display("FAIL stream_rf got=%0h/%0h/%0h exp=1/109/107", empty, rf[1], rf[15]); end
  endtask
  task automatic test_reset_mid();
    int diff;
    snap = rf;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(10 + i), 20'hC0 + 20'(i));
      step();
    end
    drive(1'b0, '0, '0);
    total++; if (pending !== 3'd3) begin bad++; $display("FAIL midreset_pre got=%0d exp=3", pending); end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    hold = 1'b0;
    #1;
    total++; if (pending !== 3'd0 || bus.WriteEnable !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL midreset_clear got=%0d/%0h/%0h exp=0/0/1", pending, bus.WriteEnable, empty); end
    step();
    step();
    diff = 0;
    for (int i = 0; i < 16; i++) if (rf[i] !== snap[i]) diff++;
    total++; if (diff != 0) begin bad++; $display("FAIL midreset_rf got=%0d changed exp=0", diff); end
  endtask
  task automatic test_empty_lookup();
    rd_addr1 = 4'd9;
    rd_addr2 = 4'd9;
    #1;
    total++; if (rd_hit1 !== 1'b0 || rd_hit2 !== 1'b0 || rd_data1 !== 20'h0 || rd_data2 !== 20'h0) begin bad++; $display("FAIL empty_lookup got=%0h/%0h/%0h/%0h exp=0/0/0/0", rd_hit1, rd_hit2, rd_data1, rd_data2); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_full();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    test_empty_lookup();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
